// File: rtl/fft_pkg.sv
// Shared definitions for the FFT frame sequencer: FSM state encoding,
// reset config word and the config word bit-field layout.
package fft_pkg;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_CFG    = 2'd1;
   localparam logic [1:0] ST_STREAM = 2'd2;

   localparam logic [7:0] CFG_DEFAULT_WORD = 8'h01;

   localparam int unsigned INFLIGHT_W = 4;

   // Core config word: bit0 selects forward/inverse, bits7:1 carry the scale schedule.
   typedef struct packed {
      logic [6:0] scale;
      logic       fwd_inv;
   } fft_cfg_t;

endpackage

// File: rtl/fft_inflight_cnt.sv
// Frames-in-flight counter: +1 per admitted frame, -1 per completed result
// frame, saturating at both ends.
module fft_inflight_cnt
   import fft_pkg::*;
(
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_inc,
   input  logic                  i_dec,
   output logic [INFLIGHT_W-1:0] o_cnt
);

   logic [INFLIGHT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (i_inc && !i_dec && (cnt_q != '1)) begin
         cnt_d = cnt_q + INFLIGHT_W'(1);
      end else if (i_dec && !i_inc && (cnt_q != '0)) begin
         cnt_d = cnt_q - INFLIGHT_W'(1);
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign o_cnt = cnt_q;

endmodule

// File: rtl/fft_frame_seq.sv
// Frame sequencer in front of a streaming FFT core: inserts config transfers
// at frame boundaries, generates tlast, and limits frames in flight.
module fft_frame_seq
   import fft_pkg::*;
#(
   parameter int unsigned FRAME_LEN    = 1024,
   parameter int unsigned MAX_INFLIGHT = 2,
   parameter logic [7:0]  CFG_DEFAULT  = CFG_DEFAULT_WORD
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [7:0]  i_cfg_data,
   input  logic        i_cfg_update,
   input  logic [31:0] i_data,
   input  logic        i_data_valid,
   output logic        o_data_ready,
   output logic [31:0] o_fft_tdata,
   output logic        o_fft_tvalid,
   output logic        o_fft_tlast,
   input  logic        i_fft_tready,
   output logic [7:0]  o_cfg_tdata,
   output logic        o_cfg_tvalid,
   input  logic        i_cfg_tready,
   input  logic        i_res_tvalid,
   input  logic        i_res_tready,
   input  logic        i_res_tlast,
   input  logic        i_evt_tlast_unexpected,
   input  logic        i_evt_tlast_missing,
   input  logic        i_err_clr,
   output logic [3:0]  o_inflight,
   output logic        o_busy,
   output logic [1:0]  o_err
);

   localparam int unsigned           CNT_W    = $clog2(FRAME_LEN);
   localparam logic [CNT_W-1:0]      LAST_IDX = CNT_W'(FRAME_LEN - 1);
   localparam logic [INFLIGHT_W-1:0] MAX_IF   = INFLIGHT_W'(MAX_INFLIGHT);

   logic [1:0]            state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   fft_cfg_t              cfg_q, cfg_d;
   logic                  cfg_pending_q, cfg_pending_d;
   logic [1:0]            err_q, err_d;
   logic [INFLIGHT_W-1:0] inflight;
   logic                  gate;
   logic                  fft_hs;
   logic                  frame_end;
   logic                  res_end;

   // Mealy outputs and next-state logic; the data path is a pure passthrough.
   always_comb begin
      o_fft_tdata   = i_data;
      o_fft_tvalid  = 1'b0;
      o_data_ready  = 1'b0;
      o_cfg_tvalid  = 1'b0;
      o_cfg_tdata   = cfg_q;
      state_d       = state_q;
      cnt_d         = cnt_q;
      cfg_d         = cfg_q;
      cfg_pending_d = cfg_pending_q;

      // A new frame may only start while fewer than MAX_INFLIGHT frames are outstanding.
      gate = !((cnt_q == '0) && (inflight == MAX_IF));

      if (state_q == ST_STREAM) begin
         o_fft_tvalid = i_data_valid & gate;
         o_data_ready = i_fft_tready & gate;
      end
      if (state_q == ST_CFG) begin
         o_cfg_tvalid = 1'b1;
      end

      o_fft_tlast = o_fft_tvalid && (cnt_q == LAST_IDX);
      fft_hs      = o_fft_tvalid & i_fft_tready;
      frame_end   = fft_hs & o_fft_tlast;

      if (fft_hs) begin
         cnt_d = cnt_q + CNT_W'(1);
      end

      case (state_q)
         ST_IDLE: begin
            if (cfg_pending_q) begin
               state_d = ST_CFG;
            end else if (i_data_valid) begin
               state_d = ST_STREAM;
            end
         end
         ST_CFG: begin
            if (i_cfg_tready) begin
               state_d       = ST_STREAM;
               cfg_pending_d = 1'b0;
            end
         end
         ST_STREAM: begin
            if (frame_end && (cfg_pending_q || i_cfg_update)) begin
               state_d = ST_CFG;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Updates always win over the clear from a concurrent config handshake.
      if (i_cfg_update) begin
         cfg_d         = fft_cfg_t'(i_cfg_data);
         cfg_pending_d = 1'b1;
      end

      err_d = {i_evt_tlast_missing, i_evt_tlast_unexpected} | (err_q & {2{~i_err_clr}});
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q       <= ST_IDLE;
         cnt_q         <= '0;
         cfg_q         <= fft_cfg_t'(CFG_DEFAULT);
         cfg_pending_q <= 1'b1;
         err_q         <= '0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         cfg_q         <= cfg_d;
         cfg_pending_q <= cfg_pending_d;
         err_q         <= err_d;
      end
   end

   assign res_end = i_res_tvalid & i_res_tready & i_res_tlast;

   fft_inflight_cnt u_inflight (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_inc (frame_end),
      .i_dec (res_end),
      .o_cnt (inflight)
   );

   assign o_inflight = inflight;
   assign o_busy     = (state_q != ST_IDLE) || (inflight != '0);
   assign o_err      = err_q;

endmodule

// File: tb/tb_fft_frame_seq.sv
// Directed bench for fft_frame_seq with FRAME_LEN=8, MAX_INFLIGHT=2.
module tb_fft_frame_seq;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic [7:0]  i_cfg_data;
   logic        i_cfg_update;
   logic [31:0] i_data;
   logic        i_data_valid;
   logic        o_data_ready;
   logic [31:0] o_fft_tdata;
   logic        o_fft_tvalid;
   logic        o_fft_tlast;
   logic        i_fft_tready;
   logic [7:0]  o_cfg_tdata;
   logic        o_cfg_tvalid;
   logic        i_cfg_tready;
   logic        i_res_tvalid;
   logic        i_res_tready;
   logic        i_res_tlast;
   logic        i_evt_tlast_unexpected;
   logic        i_evt_tlast_missing;
   logic        i_err_clr;
   logic [3:0]  o_inflight;
   logic        o_busy;
   logic [1:0]  o_err;

   int n_pass  = 0;
   int n_total = 0;
   int beats;

   fft_frame_seq #(
      .FRAME_LEN    (8),
      .MAX_INFLIGHT (2),
      .CFG_DEFAULT  (8'h01)
   ) dut (
      .i_clk                  (i_clk),
      .i_rst                  (i_rst),
      .i_cfg_data             (i_cfg_data),
      .i_cfg_update           (i_cfg_update),
      .i_data                 (i_data),
      .i_data_valid           (i_data_valid),
      .o_data_ready           (o_data_ready),
      .o_fft_tdata            (o_fft_tdata),
      .o_fft_tvalid           (o_fft_tvalid),
      .o_fft_tlast            (o_fft_tlast),
      .i_fft_tready           (i_fft_tready),
      .o_cfg_tdata            (o_cfg_tdata),
      .o_cfg_tvalid           (o_cfg_tvalid),
      .i_cfg_tready           (i_cfg_tready),
      .i_res_tvalid           (i_res_tvalid),
      .i_res_tready           (i_res_tready),
      .i_res_tlast            (i_res_tlast),
      .i_evt_tlast_unexpected (i_evt_tlast_unexpected),
      .i_evt_tlast_missing    (i_evt_tlast_missing),
      .i_err_clr              (i_err_clr),
      .o_inflight             (o_inflight),
      .o_busy                 (o_busy),
      .o_err                  (o_err)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge i_clk);
      #1;
   endtask

   // One accepted sample: drive, check passthrough and tlast mid-cycle, clock it in.
   task automatic beat(input logic [31:0] d, input bit last, input string tag);
      i_data = d;
      @(negedge i_clk);
      chk({tag, "_tvalid"}, 32'(o_fft_tvalid), 32'd1);
      chk({tag, "_tdata"}, o_fft_tdata, d);
      chk({tag, "_tlast"}, 32'(o_fft_tlast), 32'(last));
      cyc();
   endtask

   initial begin
      #300000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1);
   end

   initial begin
      i_rst = 1'b1; i_cfg_data = 8'h00; i_cfg_update = 1'b0;
      i_data = 32'h0; i_data_valid = 1'b0; i_fft_tready = 1'b0; i_cfg_tready = 1'b0;
      i_res_tvalid = 1'b0; i_res_tready = 1'b0; i_res_tlast = 1'b0;
      i_evt_tlast_unexpected = 1'b0; i_evt_tlast_missing = 1'b0; i_err_clr = 1'b0;

      // Reset state
      repeat (2) @(posedge i_clk);
      @(negedge i_clk);
      chk("rst_tvalid", 32'(o_fft_tvalid), 32'd0);
      chk("rst_ready", 32'(o_data_ready), 32'd0);
      chk("rst_tlast", 32'(o_fft_tlast), 32'd0);
      chk("rst_cfg_tvalid", 32'(o_cfg_tvalid), 32'd0);
      chk("rst_inflight", 32'(o_inflight), 32'd0);
      chk("rst_err", 32'(o_err), 32'd0);
      chk("rst_busy", 32'(o_busy), 32'd0);
      cyc();

      // First frame: default config transfer, then 8 beats
      i_rst = 1'b0; i_data_valid = 1'b1; i_fft_tready = 1'b1; i_cfg_tready = 1'b1;
      i_data = 32'h100;
      @(negedge i_clk);
      chk("idle_cfg_tvalid", 32'(o_cfg_tvalid), 32'd0);
      chk("idle_ready", 32'(o_data_ready), 32'd0);
      cyc();
      @(negedge i_clk);
      chk("cfg1_tvalid", 32'(o_cfg_tvalid), 32'd1);
      chk("cfg1_tdata", 32'(o_cfg_tdata), 32'h01);
      chk("cfg1_fft_tvalid", 32'(o_fft_tvalid), 32'd0);
      cyc();
      for (int k = 0; k < 8; k++) beat(32'h100 + 32'(k), k == 7, "f1");
      i_data_valid = 1'b0;
      @(negedge i_clk);
      chk("f1_inflight", 32'(o_inflight), 32'd1);
      chk("f1_busy", 32'(o_busy), 32'd1);
      chk("f1_gap_tvalid", 32'(o_fft_tvalid), 32'd0);
      cyc();

      // Mid-frame config update applies only at the frame boundary
      i_data_valid = 1'b1;
      for (int k = 0; k < 8; k++) begin
         if (k == 3) begin
            i_cfg_update = 1'b1; i_cfg_data = 8'h00;
         end
         beat(32'h200 + 32'(k), k == 7, "f2");
         i_cfg_update = 1'b0;
      end
      i_cfg_tready = 1'b0; i_data = 32'h300;
      @(negedge i_clk);
      chk("cfg2_tvalid", 32'(o_cfg_tvalid), 32'd1);
      chk("cfg2_tdata", 32'(o_cfg_tdata), 32'h00);
      chk("cfg2_fft_tvalid", 32'(o_fft_tvalid), 32'd0);
      chk("cfg2_ready", 32'(o_data_ready), 32'd0);
      chk("cfg2_inflight", 32'(o_inflight), 32'd2);
      cyc();
      i_cfg_tready = 1'b1;
      @(negedge i_clk);
      chk("cfg2_hold_tvalid", 32'(o_cfg_tvalid), 32'd1);
      cyc();

      // Inflight limit stalls sample 0 until one result frame completes
      @(negedge i_clk);
      chk("stall_ready", 32'(o_data_ready), 32'd0);
      chk("stall_tvalid", 32'(o_fft_tvalid), 32'd0);
      chk("stall_cfg_tvalid", 32'(o_cfg_tvalid), 32'd0);
      cyc();
      i_res_tvalid = 1'b1; i_res_tready = 1'b1; i_res_tlast = 1'b1;
      @(negedge i_clk);
      chk("stall2_ready", 32'(o_data_ready), 32'd0);
      cyc();
      i_res_tvalid = 1'b0; i_res_tready = 1'b0; i_res_tlast = 1'b0;
      for (int k = 0; k < 8; k++) begin
         if (k == 7) begin
            i_res_tvalid = 1'b1; i_res_tready = 1'b1; i_res_tlast = 1'b1;
         end
         beat(32'h300 + 32'(k), k == 7, "f3");
      end
      i_res_tvalid = 1'b0; i_res_tready = 1'b0; i_res_tlast = 1'b0;
      i_data_valid = 1'b0;
      @(negedge i_clk);
      chk("simul_inflight", 32'(o_inflight), 32'd1);
      cyc();

      // Sticky errors; set beats a simultaneous clear
      i_evt_tlast_unexpected = 1'b1;
      cyc();
      i_evt_tlast_unexpected = 1'b0;
      chk("err_unexp", 32'(o_err), 32'h1);
      i_evt_tlast_missing = 1'b1; i_err_clr = 1'b1;
      cyc();
      i_evt_tlast_missing = 1'b0; i_err_clr = 1'b0;
      chk("err_set_clr", 32'(o_err), 32'h2);
      i_err_clr = 1'b1;
      cyc();
      i_err_clr = 1'b0;
      chk("err_clr", 32'(o_err), 32'h0);

      // Random backpressure over 4 frames with results drained every cycle
      i_res_tvalid = 1'b1; i_res_tready = 1'b1; i_res_tlast = 1'b1;
      beats = 0;
      for (int c = 0; c < 2000 && beats < 32; c++) begin
         i_data_valid = 1'($urandom_range(0, 1));
         i_fft_tready = 1'($urandom_range(0, 1));
         i_data = 32'h1000 + 32'(beats);
         @(negedge i_clk);
         chk("rnd_tvalid", 32'(o_fft_tvalid), 32'(i_data_valid));
         chk("rnd_ready", 32'(o_data_ready), 32'(i_fft_tready));
         if (i_data_valid && i_fft_tready) begin
            chk("rnd_tdata", o_fft_tdata, 32'h1000 + 32'(beats));
            chk("rnd_tlast", 32'(o_fft_tlast), 32'((beats % 8) == 7));
            beats++;
         end
         cyc();
      end
      chk("rnd_beats", 32'(beats), 32'd32);
      i_res_tvalid = 1'b0; i_res_tready = 1'b0; i_res_tlast = 1'b0;
      i_data_valid = 1'b0; i_fft_tready = 1'b1;
      @(negedge i_clk);
      chk("rnd_inflight", 32'(o_inflight), 32'd0);
      cyc();

      // Reset at sample 5 abandons the frame
      i_data_valid = 1'b1;
      for (int k = 0; k < 5; k++) beat(32'h2000 + 32'(k), 1'b0, "pre_rst");
      i_rst = 1'b1; i_data = 32'h2005;
      cyc();
      i_rst = 1'b0; i_cfg_tready = 1'b0;
      @(negedge i_clk);
      chk("mrst_busy", 32'(o_busy), 32'd0);
      chk("mrst_tvalid", 32'(o_fft_tvalid), 32'd0);
      chk("mrst_tlast", 32'(o_fft_tlast), 32'd0);
      chk("mrst_cfg_tvalid", 32'(o_cfg_tvalid), 32'd0);
      chk("mrst_inflight", 32'(o_inflight), 32'd0);
      cyc();
      i_cfg_tready = 1'b1; i_cfg_update = 1'b1; i_cfg_data = 8'h5A;
      @(negedge i_clk);
      chk("mrst_cfg_tvalid2", 32'(o_cfg_tvalid), 32'd1);
      chk("mrst_cfg_tdata", 32'(o_cfg_tdata), 32'h01);
      cyc();
      i_cfg_update = 1'b0;

      // Update during the config handshake forces another transfer next boundary
      for (int k = 0; k < 8; k++) beat(32'h3000 + 32'(k), k == 7, "f5");
      i_data_valid = 1'b0;
      @(negedge i_clk);
      chk("cfg3_tvalid", 32'(o_cfg_tvalid), 32'd1);
      chk("cfg3_tdata", 32'(o_cfg_tdata), 32'h5A);
      chk("cfg3_inflight", 32'(o_inflight), 32'd1);
      cyc();
      @(negedge i_clk);
      chk("cfg3_done", 32'(o_cfg_tvalid), 32'd0);
      chk("cfg3_busy", 32'(o_busy), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
